// File: rtl/hyper_cfg_regs_pkg.sv
// HyperBus configuration register types.
// Field layout, register offsets and reset values.
package hyper_cfg_regs_pkg;

  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic        en_latency_additional;
    logic [15:0] t_burst_max;
    logic [3:0]  t_read_write_recovery;
    logic [3:0]  t_rx_clk_delay;
    logic [3:0]  t_tx_clk_delay;
    logic [4:0]  address_mask_msb;
    logic        address_space;
    logic        phys_in_use;
    logic        which_phy;
    logic [3:0]  t_csh_cycle;
  } hyper_cfg_t;

  // Word indexes (byte offset >> 2)
  localparam logic [5:0] OffLatAccess  = 6'd0;
  localparam logic [5:0] OffLatAddl    = 6'd1;
  localparam logic [5:0] OffBurstMax   = 6'd2;
  localparam logic [5:0] OffRwRecovery = 6'd3;
  localparam logic [5:0] OffRxDelay    = 6'd4;
  localparam logic [5:0] OffTxDelay    = 6'd5;
  localparam logic [5:0] OffAddrMask   = 6'd6;
  localparam logic [5:0] OffAddrSpace  = 6'd7;
  localparam logic [5:0] OffPhysInUse  = 6'd8;
  localparam logic [5:0] OffWhichPhy   = 6'd9;
  localparam logic [5:0] OffCshCycle   = 6'd10;
  localparam logic [5:0] OffStatus     = 6'd11;

  localparam logic [3:0]  RstLatAccess  = 4'd6;
  localparam logic        RstLatAddl    = 1'b1;
  localparam logic [15:0] RstBurstMax   = 16'd350;
  localparam logic [3:0]  RstRwRecovery = 4'd6;
  localparam logic [3:0]  RstRxDelay    = 4'd8;
  localparam logic [3:0]  RstTxDelay    = 4'd8;
  localparam logic [4:0]  RstAddrMask   = 5'd25;
  localparam logic        RstAddrSpace  = 1'b0;
  localparam logic        RstWhichPhy   = 1'b0;
  localparam logic [3:0]  RstCshCycle   = 4'd1;

  function automatic hyper_cfg_t cfg_reset(
    input int unsigned num_phys
  );
    hyper_cfg_t c;
    c.t_latency_access      = RstLatAccess;
    c.en_latency_additional = RstLatAddl;
    c.t_burst_max           = RstBurstMax;
    c.t_read_write_recovery = RstRwRecovery;
    c.t_rx_clk_delay        = RstRxDelay;
    c.t_tx_clk_delay        = RstTxDelay;
    c.address_mask_msb      = RstAddrMask;
    c.address_space         = RstAddrSpace;
    c.phys_in_use           = (num_phys == 2);
    c.which_phy             = RstWhichPhy;
    c.t_csh_cycle           = RstCshCycle;
    return c;
  endfunction

endpackage

// File: rtl/hyper_cfg_regs.sv
// HyperBus configuration register file.
// Shadow registers applied to cfg_o between PHY transactions.
module hyper_cfg_regs
  import hyper_cfg_regs_pkg::*;
#(
  parameter int unsigned NumPhys = 2,
  parameter int unsigned RegAw   = 8,
  parameter int unsigned RegDw   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reg_valid_i,
  input  logic               reg_write_i,
  input  logic [RegAw-1:0]   reg_addr_i,
  input  logic [RegDw-1:0]   reg_wdata_i,
  input  logic [RegDw/8-1:0] reg_wstrb_i,
  output logic               reg_ready_o,
  output logic               reg_error_o,
  output logic [RegDw-1:0]   reg_rdata_o,
  input  logic               trans_active_i,
  output hyper_cfg_t         cfg_o,
  output logic               cfg_update_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RESP  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam int unsigned Nb = RegDw / 8;

  logic [1:0] state;
  logic       pending;
  hyper_cfg_t shadow;

  logic             q_write;
  logic [RegAw-1:0] q_addr;
  logic [RegDw-1:0] q_wdata;
  logic [Nb-1:0]    q_wstrb;

  logic             cur_write;
  logic [RegAw-1:0] cur_addr;
  logic [RegDw-1:0] cur_wdata;
  logic [Nb-1:0]    cur_wstrb;

  logic [5:0]       idx;
  logic             err;
  logic             phy_ign;
  logic             accept;
  logic             stall_req;
  logic             commit;
  logic             wr_en;
  logic             set_pend;
  logic             apply;
  logic [RegDw-1:0] rd_word;
  logic [RegDw-1:0] merged;
  logic             unused_bits;

  // Live request in IDLE, parked request in STALL
  always_comb begin
    cur_write = reg_write_i;
    cur_addr  = reg_addr_i;
    cur_wdata = reg_wdata_i;
    cur_wstrb = reg_wstrb_i;
    if (state == STALL) begin
      cur_write = q_write;
      cur_addr  = q_addr;
      cur_wdata = q_wdata;
      cur_wstrb = q_wstrb;
    end
  end

  assign idx = cur_addr[7:2];

  assign err = (idx > OffStatus)
            || (cur_addr[1:0] != 2'b00)
            || (cur_write && idx == OffStatus);

  // Single-PHY builds keep the PHY selectors at zero
  assign phy_ign = (NumPhys == 1)
                && (idx == OffPhysInUse
                 || idx == OffWhichPhy);

  assign accept    = (state == IDLE) && reg_valid_i;
  assign stall_req = accept && reg_write_i
                  && pending && trans_active_i;
  assign commit    = (accept && !stall_req)
                  || (state == STALL && !pending);
  assign wr_en     = commit && cur_write && !err;
  assign set_pend  = wr_en && !phy_ign;
  assign apply     = pending && !trans_active_i;

  // Read mux, zero-extended fields
  always_comb begin
    rd_word = '0;
    case (idx)
      OffLatAccess:
        rd_word[3:0] = shadow.t_latency_access;
      OffLatAddl:
        rd_word[0] = shadow.en_latency_additional;
      OffBurstMax:
        rd_word[15:0] = shadow.t_burst_max;
      OffRwRecovery:
        rd_word[3:0] = shadow.t_read_write_recovery;
      OffRxDelay:
        rd_word[3:0] = shadow.t_rx_clk_delay;
      OffTxDelay:
        rd_word[3:0] = shadow.t_tx_clk_delay;
      OffAddrMask:
        rd_word[4:0] = shadow.address_mask_msb;
      OffAddrSpace:
        rd_word[0] = shadow.address_space;
      OffPhysInUse:
        rd_word[0] = shadow.phys_in_use;
      OffWhichPhy:
        rd_word[0] = shadow.which_phy;
      OffCshCycle:
        rd_word[3:0] = shadow.t_csh_cycle;
      OffStatus:
        rd_word[1:0] = {trans_active_i, pending};
      default:
        rd_word = '0;
    endcase
  end

  // Byte-lane merge of write data over current value
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < int'(Nb); i++) begin
      if (cur_wstrb[i])
        merged[i*8 +: 8] = cur_wdata[i*8 +: 8];
    end
  end

  assign unused_bits = ^merged[RegDw-1:16];

  // Handshake FSM and parked request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      q_write <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_wstrb <= '0;
    end else begin
      case (state)
        IDLE:
          if (reg_valid_i)
            state <= stall_req ? STALL : RESP;
        RESP:
          state <= IDLE;
        STALL:
          if (!pending)
            state <= RESP;
        default:
          state <= IDLE;
      endcase
      if (accept) begin
        q_write <= reg_write_i;
        q_addr  <= reg_addr_i;
        q_wdata <= reg_wdata_i;
        q_wstrb <= reg_wstrb_i;
      end
    end
  end

  // Registered response, one cycle per commit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_ready_o <= 1'b0;
      reg_error_o <= 1'b0;
      reg_rdata_o <= '0;
    end else begin
      reg_ready_o <= commit;
      reg_error_o <= commit && err;
      reg_rdata_o <= (commit && !cur_write && !err)
                   ? rd_word : '0;
    end
  end

  // Shadow field updates, truncated to field width
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow <= cfg_reset(NumPhys);
    end else if (set_pend) begin
      case (idx)
        OffLatAccess:
          shadow.t_latency_access <= merged[3:0];
        OffLatAddl:
          shadow.en_latency_additional <= merged[0];
        OffBurstMax:
          shadow.t_burst_max <= merged[15:0];
        OffRwRecovery:
          shadow.t_read_write_recovery <= merged[3:0];
        OffRxDelay:
          shadow.t_rx_clk_delay <= merged[3:0];
        OffTxDelay:
          shadow.t_tx_clk_delay <= merged[3:0];
        OffAddrMask:
          shadow.address_mask_msb <= merged[4:0];
        OffAddrSpace:
          shadow.address_space <= merged[0];
        OffPhysInUse:
          shadow.phys_in_use <= merged[0];
        OffWhichPhy:
          shadow.which_phy <= merged[0];
        OffCshCycle:
          shadow.t_csh_cycle <= merged[3:0];
        default: ;
      endcase
    end
  end

  // Apply shadow when the PHY is idle; a same-cycle
  // write keeps pending so it lands on the next apply
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending      <= 1'b0;
      cfg_o        <= cfg_reset(NumPhys);
      cfg_update_o <= 1'b0;
    end else begin
      cfg_update_o <= apply;
      if (apply)
        cfg_o <= shadow;
      if (set_pend)
        pending <= 1'b1;
      else if (apply)
        pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hyper_cfg_regs.sv
// Directed self-checking bench for hyper_cfg_regs.
// Two instances: dual-PHY and single-PHY builds.
module tb_hyper_cfg_regs;
  import hyper_cfg_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = '0;
  logic        ta = 1'b0;

  logic        ready, error, upd;
  logic [31:0] rdata;
  hyper_cfg_t  cfg;
  logic        ready1, error1, upd1;
  logic [31:0] rdata1;
  hyper_cfg_t  cfg1;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;

  hyper_cfg_t exp_rst, exp_rst1;

  hyper_cfg_regs #(.NumPhys(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_valid_i(valid), .reg_write_i(write),
    .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_wstrb_i(strb),
    .reg_ready_o(ready), .reg_error_o(error),
    .reg_rdata_o(rdata),
    .trans_active_i(ta),
    .cfg_o(cfg), .cfg_update_o(upd)
  );

  hyper_cfg_regs #(.NumPhys(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_valid_i(valid), .reg_write_i(write),
    .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_wstrb_i(strb),
    .reg_ready_o(ready1), .reg_error_o(error1),
    .reg_rdata_o(rdata1),
    .trans_active_i(ta),
    .cfg_o(cfg1), .cfg_update_o(upd1)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (upd) upd_cnt <= upd_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic bus(
    input  logic        wr,
    input  logic [7:0]  a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    @(posedge clk); #1;
    valid = 1'b1; write = wr;
    addr = a; wdata = d; strb = s;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 20);
    rd = rdata; er = error;
    valid = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (ready !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp ready=%b error=%b exp 0 0",
               ready, error);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata got=%h exp=0", rdata);
    end
    checks++;
    if (upd !== 1'b0) begin
      errors++;
      $display("FAIL rst_upd got=%b exp=0", upd);
    end
    checks++;
    if (cfg !== exp_rst) begin
      errors++;
      $display("FAIL rst_cfg got=%h exp=%h", cfg, exp_rst);
    end
    checks++;
    if (cfg1 !== exp_rst1) begin
      errors++;
      $display("FAIL rst_cfg1 got=%h exp=%h", cfg1, exp_rst1);
    end
  endtask

  task automatic test_read_all;
    logic [31:0] ev [12];
    logic [31:0] rd;
    logic        er;
    int          lat;
    ev = '{32'd6, 32'd1, 32'd350, 32'd6, 32'd8, 32'd8,
           32'd25, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 12; i++) begin
      bus(1'b0, 8'(i*4), 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== ev[i]) begin
        errors++;
        $display("FAIL rd_%0h got=%h exp=%h", i*4, rd, ev[i]);
      end
      checks++;
      if (er !== 1'b0 || lat != 1) begin
        errors++;
        $display("FAIL rd_%0h_resp err=%b lat=%0d exp 0 1",
                 i*4, er, lat);
      end
    end
  endtask

  task automatic test_phys_write;
    logic [31:0] rd;
    logic        er;
    int          lat;
    bus(1'b1, 8'h20, 32'h0, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b0 || lat != 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL phys_wr err=%b lat=%0d rd=%h exp 0 1 0",
               er, lat, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (upd !== 1'b1 || cfg.phys_in_use !== 1'b0) begin
      errors++;
      $display("FAIL phys_apply upd=%b piu=%b exp 1 0",
               upd, cfg.phys_in_use);
    end
    bus(1'b0, 8'h2C, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL phys_status got=%h exp=0", rd);
    end
  endtask

  task automatic test_wstrb;
    logic [31:0] rd;
    logic        er;
    int          lat;
    bus(1'b1, 8'h08, 32'hABCD_1234, 4'b0001, rd, er, lat);
    bus(1'b0, 8'h08, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_0134) begin
      errors++;
      $display("FAIL wstrb_burst got=%h exp=00000134", rd);
    end
    checks++;
    if (cfg.t_burst_max !== 16'h0134) begin
      errors++;
      $display("FAIL wstrb_cfg got=%h exp=0134",
               cfg.t_burst_max);
    end
    bus(1'b1, 8'h18, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    bus(1'b0, 8'h18, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_001F) begin
      errors++;
      $display("FAIL trunc_mask got=%h exp=0000001f", rd);
    end
    bus(1'b1, 8'h28, 32'h0000_000F, 4'h0, rd, er, lat);
    bus(1'b0, 8'h28, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL nostrb_csh got=%h exp=1", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          c0;
    repeat (2) @(posedge clk);
    #1 c0 = upd_cnt;
    bus(1'b0, 8'h40, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
      errors++;
      $display("FAIL err_unmapped err=%b rd=%h lat=%0d exp 1 0 1",
               er, rd, lat);
    end
    bus(1'b1, 8'h2C, 32'h3, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_wr_status err=%b exp=1", er);
    end
    bus(1'b0, 8'h02, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_misalign err=%b exp=1", er);
    end
    bus(1'b1, 8'h01, 32'hF, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL err_wr_misalign err=%b exp=1", er);
    end
    bus(1'b0, 8'h00, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'd6 || er !== 1'b0) begin
      errors++;
      $display("FAIL err_nochange rd=%h err=%b exp 6 0", rd, er);
    end
    bus(1'b0, 8'h2C, 32'h0, 4'h0, rd, er, lat);
    @(posedge clk); #1;
    checks++;
    if (rd !== 32'h0 || upd_cnt != c0) begin
      errors++;
      $display("FAIL err_noupd status=%h pulses=%0d exp 0 0",
               rd, upd_cnt - c0);
    end
  endtask

  task automatic test_stall;
    logic [31:0] rd;
    logic        er;
    int          lat;
    ta = 1'b1;
    bus(1'b1, 8'h00, 32'h4, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b0 || lat != 1 || cfg.t_latency_access !== 4'd6) begin
      errors++;
      $display("FAIL stall_first err=%b lat=%0d lat_acc=%0d exp 0 1 6",
               er, lat, cfg.t_latency_access);
    end
    @(posedge clk); #1;
    valid = 1'b1; write = 1'b1;
    addr = 8'h0C; wdata = 32'h3; strb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || upd !== 1'b0 || cfg.t_latency_access !== 4'd6) begin
      errors++;
      $display("FAIL stall_hold ready=%b upd=%b lat_acc=%0d exp 0 0 6",
               ready, upd, cfg.t_latency_access);
    end
    ta = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (upd !== 1'b1 || cfg.t_latency_access !== 4'd4 || ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_apply1 upd=%b lat_acc=%0d ready=%b exp 1 4 0",
               upd, cfg.t_latency_access, ready);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || error !== 1'b0 || upd !== 1'b0) begin
      errors++;
      $display("FAIL stall_ack ready=%b err=%b upd=%b exp 1 0 0",
               ready, error, upd);
    end
    valid = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (upd !== 1'b1 || cfg.t_read_write_recovery !== 4'd3) begin
      errors++;
      $display("FAIL stall_apply2 upd=%b rwr=%0d exp 1 3",
               upd, cfg.t_read_write_recovery);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic        er;
    int          lat;
    ta = 1'b1;
    bus(1'b1, 8'h10, 32'h5, 4'hF, rd, er, lat);
    @(posedge clk); #1;
    valid = 1'b1; write = 1'b1;
    addr = 8'h14; wdata = 32'h7; strb = 4'hF;
    ta = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || upd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack ready=%b upd=%b exp 1 1", ready, upd);
    end
    checks++;
    if (cfg.t_rx_clk_delay !== 4'd5 || cfg.t_tx_clk_delay !== 4'd8) begin
      errors++;
      $display("FAIL b2b_pre rx=%0d tx=%0d exp 5 8",
               cfg.t_rx_clk_delay, cfg.t_tx_clk_delay);
    end
    valid = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (upd !== 1'b1 || cfg.t_tx_clk_delay !== 4'd7) begin
      errors++;
      $display("FAIL b2b_post upd=%b tx=%0d exp 1 7",
               upd, cfg.t_tx_clk_delay);
    end
  endtask

  task automatic test_single_phy_reset;
    logic [31:0] rd;
    logic        er;
    int          lat;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ta = 1'b1;
    bus(1'b1, 8'h20, 32'h1, 4'hF, rd, er, lat);
    checks++;
    if (ready1 !== 1'b1 || error1 !== 1'b0) begin
      errors++;
      $display("FAIL sp_wr ready1=%b err1=%b exp 1 0",
               ready1, error1);
    end
    bus(1'b0, 8'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rdata1 !== 32'h0 || rd !== 32'h1) begin
      errors++;
      $display("FAIL sp_rd single=%h dual=%h exp 0 1", rdata1, rd);
    end
    bus(1'b0, 8'h2C, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rdata1 !== 32'h2 || rd !== 32'h3) begin
      errors++;
      $display("FAIL sp_status single=%h dual=%h exp 2 3", rdata1, rd);
    end
    @(posedge clk); #1;
    valid = 1'b1; write = 1'b1;
    addr = 8'h00; wdata = 32'h9; strb = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL sp_stall ready=%b exp=0", ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || upd !== 1'b0 || cfg !== exp_rst) begin
      errors++;
      $display("FAIL rst_stall ready=%b upd=%b cfg=%h exp 0 0 %h",
               ready, upd, cfg, exp_rst);
    end
    checks++;
    if (cfg1 !== exp_rst1) begin
      errors++;
      $display("FAIL rst_stall1 cfg1=%h exp=%h", cfg1, exp_rst1);
    end
    valid = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus(1'b0, 8'h2C, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL rst_pending status=%h exp=2", rd);
    end
    bus(1'b0, 8'h00, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'd6 || rdata1 !== 32'd6) begin
      errors++;
      $display("FAIL rst_discard dual=%h single=%h exp 6 6",
               rd, rdata1);
    end
    ta = 1'b0;
  endtask

  initial begin
    exp_rst.t_latency_access      = 4'd6;
    exp_rst.en_latency_additional = 1'b1;
    exp_rst.t_burst_max           = 16'd350;
    exp_rst.t_read_write_recovery = 4'd6;
    exp_rst.t_rx_clk_delay        = 4'd8;
    exp_rst.t_tx_clk_delay        = 4'd8;
    exp_rst.address_mask_msb      = 5'd25;
    exp_rst.address_space         = 1'b0;
    exp_rst.phys_in_use           = 1'b1;
    exp_rst.which_phy             = 1'b0;
    exp_rst.t_csh_cycle           = 4'd1;
    exp_rst1 = exp_rst;
    exp_rst1.phys_in_use = 1'b0;
    #12;
    test_reset;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_read_all;
    test_phys_write;
    test_wstrb;
    test_errors;
    test_stall;
    test_back_to_back;
    test_single_phy_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
